// File: rtl/coherence_bus_arbiter_if.sv
// Bus bundle between the dual-core cache pair, the arbiter and the RAM port.
// master = arbiter side, slave = caches plus memory model.
interface coherence_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]             iREN, iwait;
  logic [1:0][ADDR_W-1:0] iaddr;
  logic [1:0][DATA_W-1:0] iload;
  logic [1:0]             dREN, dWEN, dwait;
  logic [1:0][ADDR_W-1:0] daddr;
  logic [1:0][DATA_W-1:0] dstore, dload;
  logic [1:0]             cctrans, ccwrite, ccwait, ccinv;
  logic [1:0][ADDR_W-1:0] ccsnoopaddr;
  logic                   ramREN, ramWEN, ram_ready;
  logic [ADDR_W-1:0]      ramaddr;
  logic [DATA_W-1:0]      ramstore, ramload;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ram_ready,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ram_ready,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// Dual-core memory bus controller: arbitrates icache/dcache traffic onto one RAM
// port and sequences snooping coherence between the two dcaches.
module coherence_bus_arbiter (
  input logic                     CLK,
  input logic                     RST,
  coherence_bus_arbiter_if.master bus
);
  typedef enum logic [3:0] {
    IDLE_B, ICACHE, SNOOP, LD1, LD2, WB1, WB2, C2C1, C2C2
  } state_t;

  state_t     state, state_nxt;
  logic       g, g_nxt;
  logic       d_last, d_last_nxt;
  logic       i_last, i_last_nxt;
  logic       o, dg, ig;
  logic [1:0] dreq;

  // ccwait is only raised outside IDLE_B, so a held snoopee can never be granted.
  assign o    = ~g;
  assign dreq = bus.dREN | bus.dWEN | bus.cctrans;
  assign dg   = dreq[d_last] ? d_last : ~d_last;
  assign ig   = bus.iREN[i_last] ? i_last : ~i_last;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE_B;
      g      <= 1'b0;
      d_last <= 1'b0;
      i_last <= 1'b0;
    end else begin
      state  <= state_nxt;
      g      <= g_nxt;
      d_last <= d_last_nxt;
      i_last <= i_last_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    g_nxt           = g;
    d_last_nxt      = d_last;
    i_last_nxt      = i_last;
    bus.iwait       = 2'b11;
    bus.iload       = '0;
    bus.dwait       = 2'b11;
    bus.dload       = '0;
    bus.ccwait      = 2'b00;
    bus.ccinv       = 2'b00;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;

    case (state)
      IDLE_B: begin
        if (|dreq) begin
          g_nxt = dg;
          if (bus.dWEN[dg])         state_nxt = WB1;
          else if (bus.cctrans[dg]) state_nxt = SNOOP;
          else                      state_nxt = LD1;
        end else if (|bus.iREN) begin
          g_nxt     = ig;
          state_nxt = ICACHE;
        end
      end

      ICACHE: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr[g];
        if (bus.ram_ready) begin
          bus.iwait[g] = 1'b0;
          bus.iload[g] = bus.ramload;
          i_last_nxt   = o;
          state_nxt    = IDLE_B;
        end
      end

      WB1, WB2: begin
        bus.ramWEN   = 1'b1;
        bus.ramaddr  = bus.daddr[g];
        bus.ramstore = bus.dstore[g];
        if (bus.ram_ready) begin
          bus.dwait[g] = 1'b0;
          if (state == WB1) state_nxt = WB2;
          else begin
            d_last_nxt = o;
            state_nxt  = IDLE_B;
          end
        end
      end

      SNOOP: begin
        bus.ccwait[o]      = 1'b1;
        bus.ccsnoopaddr[o] = bus.daddr[g];
        bus.ccinv[o]       = bus.ccwrite[g];
        // No fill and no writeback pending means an S->M upgrade: done once snooped.
        if (bus.cctrans[g] && !bus.dREN[g]) begin
          bus.dwait[g] = 1'b0;
          d_last_nxt   = o;
          state_nxt    = IDLE_B;
        end else if (bus.ccwrite[o]) state_nxt = C2C1;
        else                         state_nxt = LD1;
      end

      LD1, LD2: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.daddr[g];
        if (bus.ram_ready) begin
          bus.dwait[g] = 1'b0;
          bus.dload[g] = bus.ramload;
          if (state == LD1) state_nxt = LD2;
          else begin
            d_last_nxt = o;
            state_nxt  = IDLE_B;
          end
        end
      end

      C2C1, C2C2: begin
        // Dirty owner supplies the block; memory is updated in the same beat.
        bus.ccwait[o] = 1'b1;
        bus.ramWEN    = 1'b1;
        bus.ramaddr   = bus.daddr[o];
        bus.ramstore  = bus.dstore[o];
        bus.dload[g]  = bus.dstore[o];
        if (bus.ram_ready) begin
          bus.dwait = 2'b00;
          if (state == C2C1) state_nxt = C2C2;
          else begin
            d_last_nxt = o;
            state_nxt  = IDLE_B;
          end
        end
      end

      default: state_nxt = IDLE_B;
    endcase
  end
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench: RAM model with programmable latency, scoreboard of expected
// completion beats (icache word, dcache word, RAM write) popped by a monitor.
module tb_coherence_bus_arbiter;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ram_ready = 1'b0;
  int   rcnt = 0;
  int   lat = 1;
  int   tests = 0;
  int   fails = 0;

  typedef struct packed {
    logic [1:0]  kind;   // 0 icache word, 1 dcache word, 2 RAM write
    logic        core;
    logic [31:0] addr;   // ramaddr seen on the completing cycle
    logic [31:0] data;
    logic        chk;
  } ev_t;
  ev_t exp_q[$];

  coherence_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  coherence_bus_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ram_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction

  assign bus.ram_ready = ram_ready;
  assign bus.ramload   = ram_ready ? ram_data(bus.ramaddr) : 32'h0;

  always @(posedge CLK) begin
    if (RST) begin
      rcnt <= 0;
      ram_ready <= 1'b0;
    end else if (ram_ready) begin
      rcnt <= 0;
      ram_ready <= 1'b0;
    end else if (bus.ramREN || bus.ramWEN) begin
      if (rcnt >= lat - 1) ram_ready <= 1'b1;
      else rcnt <= rcnt + 1;
    end
  end

  function automatic void push(input logic [1:0] k, input logic c, input logic [31:0] a,
                               input logic [31:0] d, input logic ck);
    ev_t e;
    e.kind = k; e.core = c; e.addr = a; e.data = d; e.chk = ck;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_ev(input logic [1:0] k, input logic c, input logic [31:0] d);
    ev_t e;
    tests++;
    assert (exp_q.size() > 0) else begin
      fails++;
      $error("FAIL ev_unexpected kind=%0d core=%0d addr=%h data=%h exp=none", k, c, bus.ramaddr, d);
    end
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    tests++;
    assert ({k, c, bus.ramaddr} === {e.kind, e.core, e.addr}) else begin
      fails++;
      $error("FAIL ev_key got kind=%0d core=%0d addr=%h exp kind=%0d core=%0d addr=%h",
             k, c, bus.ramaddr, e.kind, e.core, e.addr);
    end
    if (e.chk) begin
      tests++;
      assert (d === e.data) else begin
        fails++;
        $error("FAIL ev_data kind=%0d core=%0d got=%h exp=%h", k, c, d, e.data);
      end
    end
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic wait_low(input int c, input bit is_i, input string tag);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge CLK); n++;
      seen = is_i ? (bus.iwait[c] === 1'b0) : (bus.dwait[c] === 1'b0);
    end
    tests++;
    assert (seen) else begin
      fails++;
      $error("FAIL %s timeout core=%0d got=no completion in %0d cycles exp=completion", tag, c, n);
    end
  endtask

  task automatic i_read(input int c, input logic [31:0] a, input bit stable, input string tag);
    int n = 0;
    bit seen = 1'b0;
    bus.iREN[c] = 1'b1; bus.iaddr[c] = a;
    while (!seen && n < 200) begin
      @(negedge CLK); n++;
      seen = (bus.iwait[c] === 1'b0);
      if (!seen && stable && n > 1) chk({tag, "_hold"}, {bus.ramREN, bus.ramaddr}, {1'b1, a});
    end
    tests++;
    assert (seen) else begin
      fails++;
      $error("FAIL %s timeout core=%0d got=no completion exp=completion", tag, c);
    end
    tick;
    bus.iREN[c] = 1'b0;
  endtask

  task automatic d_read(input int c, input logic [31:0] a, input string tag);
    bus.dREN[c] = 1'b1; bus.cctrans[c] = 1'b1; bus.ccwrite[c] = 1'b0; bus.daddr[c] = a;
    wait_low(c, 1'b0, tag);
    tick;
    bus.daddr[c] = a + 32'd4;
    wait_low(c, 1'b0, tag);
    tick;
    bus.dREN[c] = 1'b0; bus.cctrans[c] = 1'b0;
  endtask

  task automatic d_write(input int c, input logic [31:0] a, input logic [31:0] d1,
                         input logic [31:0] d2, input string tag);
    bus.dWEN[c] = 1'b1; bus.daddr[c] = a; bus.dstore[c] = d1;
    wait_low(c, 1'b0, tag);
    tick;
    bus.daddr[c] = a + 32'd4; bus.dstore[c] = d2;
    wait_low(c, 1'b0, tag);
    tick;
    bus.dWEN[c] = 1'b0;
  endtask

  task automatic snoop_supply(input int c, input logic [31:0] a, input logic [31:0] d1,
                              input logic [31:0] d2, input logic inv);
    int n = 0;
    bus.ccwrite[c] = 1'b1;
    do begin @(negedge CLK); n++; end while (bus.ccwait[c] !== 1'b1 && n < 200);
    chk("snoop_ccwait", bus.ccwait[c], 1'b1);
    chk("snoop_addr", bus.ccsnoopaddr[c], a);
    chk("snoop_ccinv", bus.ccinv[c], inv);
    chk("snoop_no_ram", {bus.ramREN, bus.ramWEN}, 2'b00);
    bus.dWEN[c] = 1'b1; bus.daddr[c] = a; bus.dstore[c] = d1;
    wait_low(c, 1'b0, "c2c_owner_w1");
    tick;
    bus.daddr[c] = a + 32'd4; bus.dstore[c] = d2;
    wait_low(c, 1'b0, "c2c_owner_w2");
    tick;
    bus.dWEN[c] = 1'b0; bus.ccwrite[c] = 1'b0;
  endtask

  initial begin
    int n;
    bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0; bus.daddr = '0;
    bus.dstore = '0; bus.cctrans = '0; bus.ccwrite = '0;

    // Completion monitor: fixed order within a cycle is I0, I1, D0, D1, W.
    fork
      forever begin
        @(negedge CLK);
        for (int c = 0; c < 2; c++)
          if (bus.iwait[c] === 1'b0) check_ev(2'd0, 1'(c), bus.iload[c]);
        for (int c = 0; c < 2; c++)
          if (bus.dwait[c] === 1'b0) check_ev(2'd1, 1'(c), bus.dload[c]);
        if (bus.ramWEN === 1'b1 && ram_ready) check_ev(2'd2, 1'b0, bus.ramstore);
      end
    join_none

    // Reset
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_iwait", bus.iwait, 2'b11);
    chk("rst_dwait", bus.dwait, 2'b11);
    chk("rst_ram_en", {bus.ramREN, bus.ramWEN}, 2'b00);
    chk("rst_cc", {bus.ccwait, bus.ccinv}, 4'b0000);
    chk("rst_ramaddr", bus.ramaddr, 32'h0);
    chk("rst_ramstore", bus.ramstore, 32'h0);
    chk("rst_iload", bus.iload, 64'h0);
    chk("rst_dload", bus.dload, 64'h0);
    chk("rst_snoopaddr", bus.ccsnoopaddr, 64'h0);
    tick;

    // Single icache read, 3-cycle latency
    lat = 3;
    push(2'd0, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b1);
    i_read(0, 32'h100, 1'b1, "ifetch");

    // Contention from reset pointers: d0, then d1, then icache 1
    lat = 1;
    push(2'd1, 1'b0, 32'h300, ram_data(32'h300), 1'b1);
    push(2'd1, 1'b0, 32'h304, ram_data(32'h304), 1'b1);
    push(2'd1, 1'b1, 32'h400, ram_data(32'h400), 1'b1);
    push(2'd1, 1'b1, 32'h404, ram_data(32'h404), 1'b1);
    push(2'd0, 1'b1, 32'h500, ram_data(32'h500), 1'b1);
    fork
      d_read(0, 32'h300, "rr1_d0");
      d_read(1, 32'h400, "rr1_d1");
      i_read(1, 32'h500, 1'b0, "rr1_i1");
    join

    // Core0 writeback flips the dcache pointer to core1
    lat = 2;
    push(2'd1, 1'b0, 32'h600, 32'h0, 1'b0);
    push(2'd2, 1'b0, 32'h600, 32'hA1, 1'b1);
    push(2'd1, 1'b0, 32'h604, 32'h0, 1'b0);
    push(2'd2, 1'b0, 32'h604, 32'hA2, 1'b1);
    d_write(0, 32'h600, 32'hA1, 32'hA2, "wb0");

    // Second contention: core1 first
    lat = 1;
    push(2'd1, 1'b1, 32'h800, ram_data(32'h800), 1'b1);
    push(2'd1, 1'b1, 32'h804, ram_data(32'h804), 1'b1);
    push(2'd1, 1'b0, 32'h700, ram_data(32'h700), 1'b1);
    push(2'd1, 1'b0, 32'h704, ram_data(32'h704), 1'b1);
    fork
      d_read(0, 32'h700, "rr2_d0");
      d_read(1, 32'h800, "rr2_d1");
    join

    // Dirty miss: core1 supplies the block, memory updated
    lat = 2;
    push(2'd1, 1'b0, 32'h200, 32'h11, 1'b1);
    push(2'd1, 1'b1, 32'h200, 32'h0, 1'b0);
    push(2'd2, 1'b0, 32'h200, 32'h11, 1'b1);
    push(2'd1, 1'b0, 32'h204, 32'h22, 1'b1);
    push(2'd1, 1'b1, 32'h204, 32'h0, 1'b0);
    push(2'd2, 1'b0, 32'h204, 32'h22, 1'b1);
    fork
      d_read(0, 32'h200, "c2c_req");
      snoop_supply(1, 32'h200, 32'h11, 32'h22, 1'b0);
    join

    // Core1 S->M upgrade: one snoop cycle, no RAM traffic
    push(2'd1, 1'b1, 32'h0, 32'h0, 1'b0);
    bus.daddr[1] = 32'h900; bus.cctrans[1] = 1'b1; bus.ccwrite[1] = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (bus.ccwait[0] !== 1'b1 && n < 200);
    chk("upg_ccwait", bus.ccwait[0], 1'b1);
    chk("upg_ccinv", bus.ccinv[0], 1'b1);
    chk("upg_snoopaddr", bus.ccsnoopaddr[0], 32'h900);
    chk("upg_dwait", bus.dwait, 2'b01);
    chk("upg_no_ram", {bus.ramREN, bus.ramWEN}, 2'b00);
    tick;
    bus.cctrans[1] = 1'b0; bus.ccwrite[1] = 1'b0;
    @(negedge CLK);
    chk("upg_done_ccwait", bus.ccwait, 2'b00);
    tick;

    // Reset during LD2 abandons the fill
    lat = 3;
    push(2'd1, 1'b0, 32'hA00, ram_data(32'hA00), 1'b1);
    bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.ccwrite[0] = 1'b0; bus.daddr[0] = 32'hA00;
    wait_low(0, 1'b0, "rst_ld_w1");
    tick;
    bus.daddr[0] = 32'hA04;
    @(negedge CLK);
    chk("ld2_active", {bus.ramREN, bus.ramaddr}, {1'b1, 32'hA04});
    RST = 1'b1;
    tick;
    RST = 1'b0; bus.dREN[0] = 1'b0; bus.cctrans[0] = 1'b0;
    @(negedge CLK);
    chk("midrst_ram_en", {bus.ramREN, bus.ramWEN}, 2'b00);
    chk("midrst_dwait", bus.dwait, 2'b11);
    tick;

    lat = 1;
    push(2'd1, 1'b1, 32'hB00, ram_data(32'hB00), 1'b1);
    push(2'd1, 1'b1, 32'hB04, ram_data(32'hB04), 1'b1);
    d_read(1, 32'hB00, "post_rst_d1");

    repeat (5) tick;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
